// File: rtl/mult_div_unit_pkg.sv
// Shared MDU constants: op encodings and default busy-cycle counts,
// also referenced by control decode and the hazard unit.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MFHI  = 3'd6;
    localparam logic [2:0] MD_MFLO  = 3'd7;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Ops 0-3 occupy the unit for several cycles; 4-7 are single-cycle moves.
    function automatic logic md_is_long(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational multiply/divide datapath producing the HI/LO pair for ops 0-3.
// All multiply and divide operators of the unit live here.
module md_compute
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             dbz
);

    logic signed [2*WIDTH-1:0] w_sprod;
    logic        [2*WIDTH-1:0] w_uprod;
    logic        [WIDTH-1:0]   w_div_b;
    logic signed [WIDTH-1:0]   w_squot;
    logic signed [WIDTH-1:0]   w_srem;
    logic        [WIDTH-1:0]   w_uquot;
    logic        [WIDTH-1:0]   w_urem;
    logic                      w_b_zero;
    logic                      w_ovf;

    assign w_sprod = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign w_uprod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign w_b_zero = (B == '0);
    assign w_ovf    = (op == MD_DIV) && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    // Dividing by 1 instead of 0 keeps the divider X-free, and for
    // MIN / -1 it yields exactly the required quotient MIN with remainder 0.
    assign w_div_b = (w_b_zero || w_ovf) ? WIDTH'(1) : B;

    assign w_squot = $signed(A) / $signed(w_div_b);
    assign w_srem  = $signed(A) % $signed(w_div_b);
    assign w_uquot = A / w_div_b;
    assign w_urem  = A % w_div_b;

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        case (op)
            MD_MULT:  begin hi_res = w_sprod[2*WIDTH-1:WIDTH]; lo_res = w_sprod[WIDTH-1:0]; end
            MD_MULTU: begin hi_res = w_uprod[2*WIDTH-1:WIDTH]; lo_res = w_uprod[WIDTH-1:0]; end
            MD_DIV:   begin hi_res = w_srem;  lo_res = w_squot; end
            MD_DIVU:  begin hi_res = w_urem;  lo_res = w_uquot; end
            default:  begin hi_res = '0;      lo_res = '0;      end
        endcase
    end

    assign dbz = w_b_zero && md_is_div(op);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MDU: latches a computed result on start, holds busy for the
// op's cycle count, then commits it to HI/LO. Also handles mthi/mtlo/mfhi/mflo.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_pend;
    logic [WIDTH-1:0] r_lo_pend;
    logic             r_dbz_pend;

    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;
    logic             w_dbz;

    md_compute #(.WIDTH(WIDTH)) u_compute (
        .A      (A),
        .B      (B),
        .op     (op),
        .hi_res (w_hi_res),
        .lo_res (w_lo_res),
        .dbz    (w_dbz)
    );

    // Handshake: an MDU instruction is accepted when valid is high and the unit
    // is idle; long ops (0-3) are accepted via start, moves via mthi/mtlo. Any
    // valid op 0-5 seen while busy is dropped, since the hazard unit stalls it.
    assign start = valid && md_is_long(op) && !r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_hi_pend  <= '0;
            r_lo_pend  <= '0;
            r_dbz_pend <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (!r_dbz_pend) begin
                    r_hi <= r_hi_pend;
                    r_lo <= r_lo_pend;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (start) begin
            r_busy     <= 1'b1;
            r_cnt      <= md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_hi_pend  <= w_hi_res;
            r_lo_pend  <= w_lo_res;
            r_dbz_pend <= w_dbz;
        end else if (valid && (op == MD_MTHI)) begin
            r_hi <= A;
        end else if (valid && (op == MD_MTLO)) begin
            r_lo <= A;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        out = '0;
        if (op == MD_MFHI) begin
            out = r_hi;
        end else if (op == MD_MFLO) begin
            out = r_lo;
        end
    end

endmodule
